mem_arbiter: RTL and testbench

Two-port arbiter that shares the single 4K x 16 program/data memory between the `cpu` (port 0) and a secondary master such as a program loader or debug/DMA port (port 1). It sits between the masters and the `memory` instance: it owns the memory address, data, `rdwr` and `en` lines and serialises accesses with a req/ack handshake. It also supports a port-0 lock so the CPU can complete read-modify-write sequences (ISZ-style) without interleaving.

---
 rtl/mem_arbiter.sv | 168 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port arbiter that puts the cpu (port 0) and a secondary
// master (port 1) onto the single 4K x 16 memory. It uses a req/ack handshake
// and lets port 0 hold a lock, so that a read-modify-write pair is never split
// by the other port.
// Optional build macro ARB_ROUND_ROBIN_EN: round-robin tie resolution.
// Without the macro, ties use fixed priority with port 0 winning.
module mem_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [11:0] addr0,
  input  logic [11:0] addr1,
  input  logic [15:0] wdata0,
  input  logic [15:0] wdata1,
  input  logic        lock0,
  output logic        ack0,
  output logic        ack1,
  output logic [15:0] rdata0,
  output logic [15:0] rdata1,
  output logic        gnt,
  output logic        busy,
  output logic [11:0] mem_addr,
  output logic [15:0] mem_dout,
  input  logic [15:0] mem_din,
  output logic        mem_rdwr,
  output logic        mem_en
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP, S_LOCKED} state_t;

  state_t      state_q, state_d;
  logic        gnt_q, gnt_d;
  logic        we_q, we_d;
  logic        ack0_q, ack0_d, ack1_q, ack1_d;
  logic        busy_q, busy_d;
  logic        mem_en_q, mem_en_d, mem_rdwr_q, mem_rdwr_d;
  logic [11:0] mem_addr_q, mem_addr_d;
  logic [15:0] mem_dout_q, mem_dout_d;
  logic [15:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic        take, take_port, p1_ok;
`ifdef ARB_ROUND_ROBIN_EN
  logic        rr_q, rr_d;   // port that wins the next tie
`endif

  // next-state, winner selection and registered-output values
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    we_d       = we_q;
    ack0_d     = 1'b0;
    ack1_d     = 1'b0;
    mem_en_d   = 1'b0;
    mem_rdwr_d = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_dout_d = mem_dout_q;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;
    take       = 1'b0;
    take_port  = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    rr_d       = rr_q;
    p1_ok      = 1'b1;
`else
    // Fixed priority: port 1 may follow a port-0 access only when req0 is low.
    p1_ok      = !req0;
`endif
    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          take = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
          take_port = (req0 && req1) ? rr_q : req1;
`else
          take_port = !req0;
`endif
        end
      end
      S_ACCESS: begin
        state_d = S_RESP;
        ack0_d  = !gnt_q;
        ack1_d  = gnt_q;
      end
      S_RESP: begin
        if (!we_q) begin
          if (gnt_q) rdata1_d = mem_din;
          else       rdata0_d = mem_din;
        end
`ifdef ARB_ROUND_ROBIN_EN
        rr_d = !gnt_q;
`endif
        // The acked port still holds its old request here, so only the other port is eligible.
        if (!gnt_q && lock0)                begin state_d = S_LOCKED; end
        else if (gnt_q && req0)             begin take = 1'b1; take_port = 1'b0; end
        else if (!gnt_q && req1 && p1_ok)   begin take = 1'b1; take_port = 1'b1; end
        else                                begin state_d = S_IDLE; end
      end
      S_LOCKED: begin
        if (req0)        begin take = 1'b1; take_port = 1'b0; end
        else if (!lock0) begin state_d = S_IDLE; end
      end
      default: state_d = S_IDLE;
    endcase
    if (take) begin
      state_d    = S_ACCESS;
      gnt_d      = take_port;
      we_d       = take_port ? we1 : we0;
      mem_en_d   = 1'b1;
      mem_rdwr_d = take_port ? we1 : we0;
      mem_addr_d = take_port ? addr1 : addr0;
      mem_dout_d = take_port ? wdata1 : wdata0;
    end
    busy_d = (state_d != S_IDLE);
  end

  // state and output registers; a synchronous reset aborts any access in flight
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      gnt_q      <= 1'b0;
      we_q       <= 1'b0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      busy_q     <= 1'b0;
      mem_en_q   <= 1'b0;
      mem_rdwr_q <= 1'b0;
      mem_addr_q <= '0;
      mem_dout_q <= '0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      rr_q       <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      we_q       <= we_d;
      ack0_q     <= ack0_d;
      ack1_q     <= ack1_d;
      busy_q     <= busy_d;
      mem_en_q   <= mem_en_d;
      mem_rdwr_q <= mem_rdwr_d;
      mem_addr_q <= mem_addr_d;
      mem_dout_q <= mem_dout_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
`ifdef ARB_ROUND_ROBIN_EN
      rr_q       <= rr_d;
`endif
    end
  end

  assign ack0     = ack0_q;
  assign ack1     = ack1_q;
  assign gnt      = gnt_q;
  assign busy     = busy_q;
  assign mem_en   = mem_en_q;
  assign mem_rdwr = mem_rdwr_q;
  assign mem_addr = mem_addr_q;
  assign mem_dout = mem_dout_q;
  // Memory dataout is already a flop. During a read ack it is forwarded
  // directly; at all other times the last read value is held in rdata*_q.
  assign rdata0   = (ack0_q && !we_q) ? mem_din : rdata0_q;
  assign rdata1   = (ack1_q && !we_q) ? mem_din : rdata1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with a behavioural
// registered-read memory and an ack-ordered scoreboard.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, we0, we1, lock0;
  logic [11:0] addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic        ack0, ack1, gnt, busy, mem_rdwr, mem_en;
  logic [15:0] rdata0, rdata1, mem_dout, mem_din;
  logic [11:0] mem_addr;

  typedef struct packed { logic en; logic rdwr; logic [11:0] addr; logic [15:0] dout; } snap_t;
  typedef struct packed { logic port; logic [15:0] data; } sb_t;

  int          passed = 0;
  int          total  = 0;
  int          cyc    = 0;
  sb_t         sbq[$];
  logic [15:0] model_mem [4096];
  logic [15:0] model_last [2];

  logic [15:0] mem [4096];
  logic [15:0] mem_q = '0;
  logic        init_done = 1'b0;

  mem_arbiter dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1), .lock0(lock0),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1), .gnt(gnt), .busy(busy),
    .mem_addr(mem_addr), .mem_dout(mem_dout), .mem_din(mem_din),
    .mem_rdwr(mem_rdwr), .mem_en(mem_en)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] pat(input int i);
    logic [15:0] v;
    v = 16'(i) ^ 16'hA5C3;
    if (i == 16) v = 16'hBEEF;
    return v;
  endfunction

  // registered-read memory; contents are loaded on the first clock edge
  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 4096; i++) mem[i] <= pat(i);
      init_done <= 1'b1;
    end else if (mem_en) begin
      if (mem_rdwr) mem[mem_addr] <= mem_dout;
      else          mem_q <= mem[mem_addr];
    end
  end
  assign mem_din = mem_q;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // scoreboard: every ack pops the oldest expectation
  always @(negedge clk) begin
    if (ack0 || ack1) begin
      sb_t e;
      check("dual_ack", 32'(ack0 && ack1), 32'd0);
      if (sbq.size() == 0) begin
        check("unexpected_ack", 32'(sbq.size()), 32'd1);
      end else begin
        e = sbq.pop_front();
        check("ack_port", 32'(ack1), 32'(e.port));
        check("ack_rdata", 32'(ack1 ? rdata1 : rdata0), 32'(e.data));
      end
    end
  end

  task automatic drive(input int port, input logic we, input logic [11:0] a, input logic [15:0] d);
    if (port == 0) begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; end
    else           begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; end
  endtask

  task automatic exp_push(input int port, input logic we, input logic [11:0] a, input logic [15:0] d);
    sb_t e;
    e.port = port[0];
    if (we) begin
      model_mem[a] = d;
      e.data = model_last[port];
    end else begin
      e.data = model_mem[a];
      model_last[port] = e.data;
    end
    sbq.push_back(e);
  endtask

  // waits for ack on a port; lat counts edges from the drive, s captures bus after the first edge
  task automatic wait_ack(input int port, output int lat, output snap_t s);
    logic got;
    got = 1'b0; lat = 0; s = '0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (lat == 1) s = {mem_en, mem_rdwr, mem_addr, mem_dout};
      if ((port == 0 && ack0) || (port == 1 && ack1)) begin got = 1'b1; break; end
    end
    if (!got) check("ack_timeout", 32'(port == 0 ? ack0 : ack1), 32'd1);
  endtask

  initial begin
    int          lat, n0, n1, prev;
    logic        drop0, drop1, done;
    snap_t       s;
    logic [15:0] wd;

    for (int i = 0; i < 4096; i++) model_mem[i] = pat(i);
    model_last[0] = '0; model_last[1] = '0;
    rst = 1'b0; req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ack0", 32'(ack0), 0);         check("rst_ack1", 32'(ack1), 0);
    check("rst_busy", 32'(busy), 0);         check("rst_gnt", 32'(gnt), 0);
    check("rst_mem_en", 32'(mem_en), 0);     check("rst_mem_rdwr", 32'(mem_rdwr), 0);
    check("rst_mem_addr", 32'(mem_addr), 0); check("rst_mem_dout", 32'(mem_dout), 0);
    check("rst_rdata0", 32'(rdata0), 0);     check("rst_rdata1", 32'(rdata1), 0);
    @(posedge clk); #1 rst = 1'b1;

    // single read on port 0
    @(posedge clk); #1;
    drive(0, 1'b0, 12'h010, 16'h0); exp_push(0, 1'b0, 12'h010, 16'h0);
    wait_ack(0, lat, s);
    check("rd0_lat", 32'(lat), 2);     check("rd0_en", 32'(s.en), 1);
    check("rd0_rdwr", 32'(s.rdwr), 0); check("rd0_addr", 32'(s.addr), 32'h010);
    @(posedge clk); #1 req0 = 1'b0;

    // port 1 write then read of the top address
    @(posedge clk); #1;
    drive(1, 1'b1, 12'hFFF, 16'h1234); exp_push(1, 1'b1, 12'hFFF, 16'h1234);
    wait_ack(1, lat, s);
    check("wr1_lat", 32'(lat), 2);       check("wr1_en", 32'(s.en), 1);
    check("wr1_rdwr", 32'(s.rdwr), 1);   check("wr1_addr", 32'(s.addr), 32'hFFF);
    check("wr1_dout", 32'(s.dout), 32'h1234);
    @(posedge clk); #1;
    drive(1, 1'b0, 12'hFFF, 16'h0); exp_push(1, 1'b0, 12'hFFF, 16'h0);
    wait_ack(1, lat, s);
    check("rd1_lat", 32'(lat), 2); check("rd1_rdwr", 32'(s.rdwr), 0);
    check("rd1_rdwr_resp", 32'(mem_rdwr), 0);
    @(posedge clk); #1 req1 = 1'b0;

    // tie: both ports request continuously
    @(posedge clk); #1;
    drive(0, 1'b0, 12'h100, 16'h0); drive(1, 1'b0, 12'h200, 16'h0);
`ifdef ARB_ROUND_ROBIN_EN
    exp_push(0, 1'b0, 12'h100, 16'h0); exp_push(1, 1'b0, 12'h200, 16'h0);
    exp_push(0, 1'b0, 12'h100, 16'h0); exp_push(1, 1'b0, 12'h200, 16'h0);
    n0 = 2; n1 = 2;
`else
    exp_push(0, 1'b0, 12'h100, 16'h0); exp_push(0, 1'b0, 12'h100, 16'h0);
    exp_push(0, 1'b0, 12'h100, 16'h0); exp_push(1, 1'b0, 12'h200, 16'h0);
    n0 = 3; n1 = 1;
`endif
    drop0 = 0; drop1 = 0; done = 0; prev = -1;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      if (drop0) req0 = 1'b0;
      if (drop1) req1 = 1'b0;
      @(negedge clk);
      if (ack0 || ack1) begin
`ifdef ARB_ROUND_ROBIN_EN
        if (prev >= 0) check("rr_spacing", 32'(cyc - prev), 2);
`endif
        prev = cyc;
        if (ack0) begin n0--; if (n0 == 0) drop0 = 1; end
        if (ack1) begin n1--; if (n1 == 0) drop1 = 1; end
      end
      if (n0 <= 0 && n1 <= 0) begin done = 1; break; end
    end
    if (!done) check("tie_timeout", 32'(n0 + n1), 0);
    @(posedge clk); #1 req0 = 1'b0; req1 = 1'b0;
    repeat (2) @(posedge clk);

    // lock: port 0 read-modify-write of 0x020 while port 1 waits for the same word
    #1;
    drive(1, 1'b0, 12'h020, 16'h0);
    drive(0, 1'b0, 12'h020, 16'h0); lock0 = 1'b1;
    exp_push(0, 1'b0, 12'h020, 16'h0);
    wait_ack(0, lat, s);
    check("lk_rd_lat", 32'(lat), 2);
    @(posedge clk); #1 req0 = 1'b0;
    @(negedge clk);
    check("lk_busy", 32'(busy), 1); check("lk_gnt", 32'(gnt), 0); check("lk_ack1", 32'(ack1), 0);
    @(posedge clk); #1;
    wd = model_mem[12'h020] + 16'd1;
    drive(0, 1'b1, 12'h020, wd); exp_push(0, 1'b1, 12'h020, wd);
    exp_push(1, 1'b0, 12'h020, 16'h0);
    wait_ack(0, lat, s);
    check("lk_wr_lat", 32'(lat), 2); check("lk_wr_rdwr", 32'(s.rdwr), 1);
    @(posedge clk); #1 req0 = 1'b0; lock0 = 1'b0;
    wait_ack(1, lat, s);
    @(posedge clk); #1 req1 = 1'b0;
    repeat (2) @(posedge clk);

    // reset during ACCESS aborts, then the first tie goes to port 0
    #1;
    drive(0, 1'b0, 12'h300, 16'h0); drive(1, 1'b0, 12'h400, 16'h0);
    @(posedge clk);
    @(negedge clk);
    check("ab_en", 32'(mem_en), 1);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("ab_ack0", 32'(ack0), 0);     check("ab_ack1", 32'(ack1), 0);
    check("ab_busy", 32'(busy), 0);     check("ab_en0", 32'(mem_en), 0);
    check("ab_gnt", 32'(gnt), 0);       check("ab_addr", 32'(mem_addr), 0);
    check("ab_rdata0", 32'(rdata0), 0); check("ab_rdata1", 32'(rdata1), 0);
    model_last[0] = '0; model_last[1] = '0;
    @(posedge clk); #1 rst = 1'b1;
    exp_push(0, 1'b0, 12'h300, 16'h0); exp_push(1, 1'b0, 12'h400, 16'h0);
    wait_ack(0, lat, s);
    check("ab_tie_lat", 32'(lat), 2);
    @(posedge clk); #1 req0 = 1'b0;
    wait_ack(1, lat, s);
    @(posedge clk); #1 req1 = 1'b0;
    repeat (3) @(posedge clk);

    @(negedge clk);
    check("sb_empty", 32'(sbq.size()), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
